// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one multiply in flight, WIDTH+1 shift/add
// iterations on sign- or zero-extended operands, valid/ready on both sides.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   q_q;
  logic [WIDTH:0]   m_q;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]     a_sum;
  logic [2*WIDTH+2:0] shifted;

  // One extra bit lets unsigned operands run through the same signed datapath.
  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // NOTE: a_sum gets a default before the case so no path leaves it unassigned;
  // otherwise synthesis would infer a latch to hold its old value.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], q_1})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    // Arithmetic right shift of {A,Q,Q_1}; the old Q_1 falls off the bottom.
    shifted = {a_sum[WIDTH], a_sum, q_q};
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking assignments would make the result order-dependent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      q_1         <= 1'b0;
      count       <= '0;
      product     <= '0;
      start_ready <= 1'b1;
      prod_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            m_q         <= ext(multiplicand, is_signed);
            q_q         <= ext(multiplier, is_signed);
            a_q         <= '0;
            q_1         <= 1'b0;
            count       <= COUNT_INIT;
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= shifted[2*WIDTH+2:WIDTH+2];
          q_q   <= shifted[WIDTH+1:1];
          q_1   <= shifted[0];
          count <= count - 1'b1;
          if (count == COUNT_LAST) begin
            // The full (WIDTH+1)-bit square product fits; keep the low 2*WIDTH bits.
            product    <= shifted[2*WIDTH:1];
            prod_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (prod_ready) begin
            prod_valid  <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          prod_valid  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomised bench for booth_mult_seq at WIDTH=8 and WIDTH=16 against an
// integer-arithmetic reference, with directed corner cases, backpressure and reset abort.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        is_signed;
  logic        prod_ready;
  logic        sel;
  logic [15:0] mc;
  logic [15:0] mq;

  logic        sv8, sr8, pv8, busy8;
  logic [15:0] p8;
  logic        sv16, sr16, pv16, busy16;
  logic [31:0] p16;

  logic        sr, pv, bz;
  logic [31:0] prod;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign sv8  = start_valid & ~sel;
  assign sv16 = start_valid & sel;
  assign sr   = sel ? sr16 : sr8;
  assign pv   = sel ? pv16 : pv8;
  assign bz   = sel ? busy16 : busy8;
  assign prod = sel ? p16 : {16'h0000, p8};

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8), .is_signed(is_signed),
    .multiplicand(mc[7:0]), .multiplier(mq[7:0]),
    .prod_valid(pv8), .prod_ready(prod_ready), .product(p8), .busy(busy8)
  );

  booth_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .start_valid(sv16), .start_ready(sr16), .is_signed(is_signed),
    .multiplicand(mc), .multiplier(mq),
    .prod_valid(pv16), .prod_ready(prod_ready), .product(p16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Product of two w-bit numbers interpreted per mode, truncated to 2w bits.
  function automatic logic [31:0] model(input int w, input bit sgn,
                                        input logic [15:0] a, input logic [15:0] b);
    longint lim, x, y, p;
    lim = longint'(1) << w;
    x = longint'(a) & (lim - 1);
    y = longint'(b) & (lim - 1);
    if (sgn && x >= lim / 2) x = x - lim;
    if (sgn && y >= lim / 2) y = y - lim;
    p = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return 32'(p);
  endfunction

  // Called at a negedge; leaves at a negedge with the DUT back in IDLE.
  task automatic do_op(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int stall, input string tag);
    int w;
    int lat;
    logic [31:0] held;
    w = sel ? 16 : 8;
    lat = 0;
    while (!sr && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!sr) begin
      check({tag, "_ready_timeout"}, 32'(sr), 32'd1);
      return;
    end
    start_valid = 1'b1;
    is_signed   = sgn;
    mc          = a;
    mq          = b;
    @(negedge clk);
    check({tag, "_busy"}, {30'd0, bz, sr}, 32'b10);
    // Scramble inputs during RUN: mode and operands must have been captured at accept.
    is_signed   = ~sgn;
    mc          = 16'($urandom);
    mq          = 16'($urandom);
    start_valid = 1'($urandom_range(0, 1));
    lat = 0;
    while (!pv && lat < 64) begin
      @(negedge clk);
      lat++;
      start_valid = 1'($urandom_range(0, 1));
    end
    check({tag, "_latency"}, 32'(lat), 32'(w + 1));
    if (!pv) return;
    check({tag, "_product"}, prod, exp);
    held = prod;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      start_valid = 1'($urandom_range(0, 1));
      check({tag, "_stall"}, {29'd0, pv, sr, bz}, 32'b101);
      check({tag, "_hold"}, prod, held);
    end
    start_valid = 1'b0;
    prod_ready  = 1'b1;
    @(negedge clk);
    prod_ready  = 1'b0;
    check({tag, "_handoff"}, {30'd0, pv, sr}, 32'b01);
  endtask

  initial begin
    int errs;
    logic [15:0] ra, rb;
    bit rs;
    rst = 1'b0; start_valid = 1'b0; is_signed = 1'b0; prod_ready = 1'b0;
    sel = 1'b0; mc = '0; mq = '0;

    repeat (2) @(negedge clk);
    check("reset8", {prod[30:0], pv, sr, bz}, 32'b010);
    sel = 1'b1;
    #1;
    check("reset16_flags", {29'd0, pv, sr, bz}, 32'b010);
    check("reset16_prod", prod, 32'd0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b1, 16'h00F9, 16'h0003, 32'h0000FFEB, 0, "s_m7x3");
    do_op(1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 0, "u_255sq");
    do_op(1'b1, 16'h0080, 16'h0080, 32'h00004000, 0, "s_m128sq");
    do_op(1'b1, 16'h007F, 16'h0080, 32'h0000C080, 5, "s_127xm128_bp");
    do_op(1'b0, 16'h00F9, 16'h0003, 32'h000002EB, 0, "u_mode_sample");
    do_op(1'b1, 16'h0000, 16'h0081, 32'h00000000, 1, "s_zero");

    // Reset aborts an operation in progress.
    start_valid = 1'b1; is_signed = 1'b1; mc = 16'h0064; mq = 16'h004D;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_flags", {29'd0, pv, sr, bz}, 32'b010);
    check("abort_prod", prod, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    errs = 0;
    repeat (12) begin
      @(negedge clk);
      if (pv) errs++;
    end
    check("abort_no_valid", 32'(errs), 32'd0);
    do_op(1'b1, 16'h000C, 16'h00FB, 32'h0000FFC4, 0, "s_12xm5");

    sel = 1'b1;
    #1;
    do_op(1'b1, 16'h8000, 16'h8000, 32'h40000000, 2, "s16_min_sq");
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, "u16_max_sq");

    for (int n = 0; n < 1000; n++) begin
      sel = (n >= 500);
      #1;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op(rs, ra, rb, model(sel ? 16 : 8, rs, ra, rb), $urandom_range(0, 3),
            sel ? "rand16" : "rand8");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
